// File: rtl/vga_sprite_compositor.sv
// VGA timing generator with a two-stage pixel pipeline that composites a tile wall map,
// N_SPR colour-keyed sprites (shadowed at frame start) and an external background.
module vga_sprite_compositor #(
    parameter int PIX_DIV   = 4,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 29,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int N_SPR     = 2,
    parameter int SPR_W     = 16,
    parameter int SPR_H     = 16,
    parameter int FRAME_W   = 2,
    parameter int ADDR_W    = 10,
    parameter int TILE_LOG2 = 5,
    parameter int MAP_W     = 20,
    parameter int MAP_H     = 15,
    parameter logic [7:0] WALL_RGB = 8'hE3,
    parameter logic [7:0] TRANSP   = 8'hFF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAP_W*MAP_H-1:0]      tile_map,
    input  logic [N_SPR*20-1:0]         spr_pos,
    input  logic [N_SPR*FRAME_W-1:0]    spr_frame,
    input  logic [N_SPR-1:0]            spr_en,
    output logic [N_SPR*ADDR_W-1:0]     spr_addr,
    input  logic [N_SPR*8-1:0]          spr_data,
    input  logic [7:0]                  bg_data,
    output logic [9:0]                  hcount,
    output logic [9:0]                  vcount,
    output logic                        pix_en,
    output logic                        frame_start,
    output logic [2:0]                  r,
    output logic [2:0]                  g,
    output logic [1:0]                  b,
    output logic                        hs,
    output logic                        vs
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HA0   = H_SYNC + H_BP;
    localparam int VA0   = V_SYNC + V_BP;
    localparam int MAP_N = MAP_W * MAP_H;
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] HS_END = 10'(H_SYNC);
    localparam logic [9:0] VS_END = 10'(V_SYNC);
    localparam logic [9:0] HA_LO  = 10'(HA0);
    localparam logic [9:0] HA_HI  = 10'(HA0 + H_ACTIVE);
    localparam logic [9:0] VA_LO  = 10'(VA0);
    localparam logic [9:0] VA_HI  = 10'(VA0 + V_ACTIVE);
    localparam logic [9:0] SW10   = 10'(SPR_W);
    localparam logic [9:0] SH10   = 10'(SPR_H);
    localparam logic [9:0] MW10   = 10'(MAP_W);
    localparam logic [9:0] MH10   = 10'(MAP_H);
    localparam logic [MAP_N-1:0] MAP_ONE = MAP_N'(1);

    logic [DIV_W-1:0]           div;
    logic [N_SPR*20-1:0]        sh_pos;
    logic [N_SPR*FRAME_W-1:0]   sh_frame;
    logic [N_SPR-1:0]           sh_en;

    logic [9:0]                 dx [N_SPR];
    logic [9:0]                 dy [N_SPR];
    logic [N_SPR-1:0]           hit_c;
    logic [N_SPR*ADDR_W-1:0]    addr_c;
    logic [9:0]                 hrel, vrel, col, row;
    logic [31:0]                tidx;
    logic                       active_c, wall_c;

    logic [N_SPR-1:0]           hit_s1;
    logic                       wall_s1, act_s1, hs_s1, vs_s1;
    logic [7:0]                 bg_s1;
    logic [7:0]                 pix_c;
    logic                       found;

    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else if (div == DIV_LAST) begin
            div    <= '0;
            pix_en <= 1'b1;
        end else begin
            div    <= div + DIV_W'(1);
            pix_en <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
            sh_pos      <= '0;
            sh_frame    <= '0;
            sh_en       <= '0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    if (vcount == V_LAST) begin
                        vcount      <= '0;
                        frame_start <= 1'b1;
                        sh_pos      <= spr_pos;
                        sh_frame    <= spr_frame;
                        sh_en       <= spr_en;
                    end else begin
                        vcount <= vcount + 10'd1;
                    end
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    // Unsigned wrap of dx/dy clips sprites hanging off any screen edge.
    always_comb begin
        hit_c  = '0;
        addr_c = '0;
        for (int unsigned i = 0; i < N_SPR; i++) begin
            dx[i] = hcount - sh_pos[20*i+10 +: 10];
            dy[i] = vcount - sh_pos[20*i +: 10];
            hit_c[i] = sh_en[i] && (dx[i] < SW10) && (dy[i] < SH10);
            addr_c[ADDR_W*i +: ADDR_W] =
                ADDR_W'(sh_frame[FRAME_W*i +: FRAME_W]) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(dy[i]) * ADDR_W'(SPR_W) + ADDR_W'(dx[i]);
        end
    end

    always_comb begin
        active_c = (hcount >= HA_LO) && (hcount < HA_HI) &&
                   (vcount >= VA_LO) && (vcount < VA_HI);
        hrel     = hcount - HA_LO;
        vrel     = vcount - VA_LO;
        col      = hrel >> TILE_LOG2;
        row      = vrel >> TILE_LOG2;
        tidx     = 32'(row) * 32'(MAP_W) + 32'(col);
        wall_c   = active_c && (col < MW10) && (row < MH10) &&
                   (|(tile_map & (MAP_ONE << tidx)));
    end

    always_comb begin
        pix_c = bg_s1;
        found = 1'b0;
        for (int unsigned i = 0; i < N_SPR; i++) begin
            if (!found && hit_s1[i] && (spr_data[8*i +: 8] != TRANSP)) begin
                pix_c = spr_data[8*i +: 8];
                found = 1'b1;
            end
        end
        if (wall_s1) pix_c = WALL_RGB;
        if (!act_s1) pix_c = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_s1   <= '0;
            wall_s1  <= 1'b0;
            act_s1   <= 1'b0;
            hs_s1    <= 1'b0;
            vs_s1    <= 1'b0;
            bg_s1    <= '0;
            spr_addr <= '0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
            hs       <= 1'b0;
            vs       <= 1'b0;
        end else if (pix_en) begin
            hit_s1    <= hit_c;
            wall_s1   <= wall_c;
            act_s1    <= active_c;
            hs_s1     <= (hcount >= HS_END);
            vs_s1     <= (vcount >= VS_END);
            bg_s1     <= bg_data;
            spr_addr  <= addr_c;
            {r, g, b} <= pix_c;
            hs        <= hs_s1;
            vs        <= vs_s1;
        end
    end

endmodule

// File: doc/vga_sprite_compositor.md
Name: vga_sprite_compositor

Overview:
- Parametrised VGA timing generator and pixel compositor for the RPG display path; next generation of the single-player/single-enemy VGA controller.
- Generates hs/vs from a divided pixel enable and composites, per pixel in this order: a tile wall map, N_SPR sprites from external sprite ROMs (fixed priority, colour-key transparency), and an external background.
- Sprite positions and frames are double-buffered at frame start, so the picture does not tear.
- Drives the 8-bit r/g/b pins directly.

Parameters:
- PIX_DIV, 4: clk cycles per pixel (pix_en period), ≥1.
- H_SYNC/H_BP/H_ACTIVE/H_FP, 96/48/640/16: horizontal timing in pixels.
- V_SYNC/V_BP/V_ACTIVE/V_FP, 2/29/480/10: vertical timing in lines.
- N_SPR, 2: sprite count (1–8).
- SPR_W/SPR_H, 16/16: sprite size in pixels.
- FRAME_W, 2: frame-select bits per sprite.
- ADDR_W, 10: sprite ROM address width; must hold 2^FRAME_W*SPR_W*SPR_H.
- TILE_LOG2, 5: tile size is 2^TILE_LOG2 pixels.
- MAP_W/MAP_H, 20/15: tile map dimensions.
- WALL_RGB, 8'hE3: wall colour {r3,g3,b2}.
- TRANSP, 8'hFF: sprite transparent key.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tile_map  in  MAP_W*MAP_H  wall bits; bit (row*MAP_W+col); 1 = wall.
- spr_pos  in  N_SPR*20  per sprite {hpos[9:0],vpos[9:0]}; sprite i at bits [20i+19:20i].
- spr_frame  in  N_SPR*FRAME_W  animation frame per sprite.
- spr_en  in  N_SPR  sprite enable.
- spr_addr  out  N_SPR*ADDR_W  sprite ROM read addresses.
- spr_data  in  N_SPR*8  ROM data; valid on the pix_en tick after the address.
- bg_data  in  8  background pixel; valid on the pix_en tick after hcount/vcount.
- hcount  out  10  current pixel column counter.
- vcount  out  10  current line counter.
- pix_en  out  1  pixel strobe.
- frame_start  out  1  one-clk pulse.
- r  out  3  red; g  out  3  green; b  out  2  blue.
- hs  out  1  horizontal sync, active low.
- vs  out  1  vertical sync, active low.

Behaviour:
- Reset (rst high at posedge clk): divider, hcount and vcount = 0; pix_en = 0; frame_start = 0; r/g/b = 0; hs = vs = 0; all pipeline and shadow registers = 0; shadow spr_en = 0.
- Reset mid-frame aborts the frame immediately. The sequence restarts at hcount = vcount = 0 on the first cycle after rst falls.
- Divider: pix_en is high for one clk every PIX_DIV clks; the first pulse is PIX_DIV clks after reset release. PIX_DIV = 1 means pix_en is held high.
- Counters advance only on pix_en. hcount wraps H_TOT-1 → 0, where H_TOT = sum of the H_* parameters. vcount increments on the hcount wrap and wraps V_TOT-1 → 0.
- Stage-0 regions:
  - hsync = hcount < H_SYNC.
  - Active area: HA0 = H_SYNC+H_BP, VA0 = V_SYNC+V_BP; active when HA0 ≤ hcount < HA0+H_ACTIVE and likewise for vcount.
- frame_start pulses on the pix_en tick where hcount wraps to 0 and vcount wraps to 0. On that same clk the shadow registers copy spr_pos/spr_frame/spr_en. Mid-frame input changes have no visible effect until the next frame.
- Stage 1 (registered on pix_en):
  - dx = hcount - hpos_i, dy = vcount - vpos_i, both 10-bit unsigned with wrap.
  - hit_i = shadow_en_i & dx < SPR_W & dy < SPR_H.
  - spr_addr_i = frame_i*SPR_W*SPR_H + dy*SPR_W + dx, truncated to ADDR_W. When there is no hit the address is don't-care but stable.
  - Tile: col = (hcount-HA0)>>TILE_LOG2, row = (vcount-VA0)>>TILE_LOG2. wall = active & col < MAP_W & row < MAP_H & tile_map[row*MAP_W+col].
  - Register hit, wall, active, hs and vs.
- Stage 2 (registered on pix_en) selects the output colour, first match wins:
  - not active → 0.
  - wall → WALL_RGB.
  - lowest index i with hit_i & spr_data_i ≠ TRANSP → spr_data_i.
  - otherwise → bg_data.
  - Output mapping: r = bits[7:5], g = [4:2], b = [1:0].
- Latency: r/g/b/hs/vs appear 2 pix_en ticks after the counter value. hs/vs are delayed by the same 2 stages, so sync stays aligned with pixels. Outputs hold between pix_en ticks.
- Sprites partly off-screen or at wrapped positions are clipped by the unsigned compare; no wrap-around artefacts. Overlapping sprites: lower index wins; a transparent lower-index pixel reveals the higher index.

Test Plan:
- Defaults, run 2 frames → hs low exactly 96 of every 800 pixels; vs low for 2 of 521 lines; frame_start period 800*521*4 clks.
- Sprite 0 at (200,100), frame 1, ROM returns addr[7:0] → pixel (205,103) has spr_addr 256+3*16+5 = 309, and r/g/b = 8'h35 two ticks later.
- Both sprites at (300,200); sprite 0 data = 8'hFF, sprite 1 data = 8'h1C → output 8'h1C. With sprite 0 data = 8'h03 → output 8'h03.
- tile_map bit 0 = 1, sprite 0 at (HA0,VA0) opaque → pixels (144..175, 31..62) show 8'hE3; pixel (176,31) shows the sprite or bg.
- Change spr_pos mid-frame → the output image changes only after the next frame_start pulse.
- Assert rst at hcount = 500 for 1 clk → all outputs 0 next cycle; after release hcount = 0 and first pix_en 4 clks later.
